// File: rtl/multicycle_processor.sv
// -----------------------------------------------------------------------------
// multicycle_processor
//
// Small multicycle load/store core with 16-bit instructions. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). One memory port is shared by
// instruction fetch and data access. It uses a req/ack handshake: the request
// stays asserted, with stable outputs, until the memory acknowledges it.
//
// Parameters
//   DATA_W   : register, ALU and memory data width (16..64)
//   ADDR_W   : PC and memory address width (8..DATA_W)
//   RESET_PC : PC value loaded on reset
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   mem_req    : memory request, held until mem_ack
//   mem_we     : 1 = store, 0 = fetch or load
//   mem_addr   : byte address of the access
//   mem_wdata  : store data
//   mem_rdata  : read data, sampled on the edge where mem_ack = 1
//   mem_ack    : access complete
//   pc         : current program counter (debug)
//   halted     : core has executed halt and stopped
//   illegal    : sticky flag, an undefined opcode was decoded
//
// Optional build macro PROC_PERF_CNT_EN adds two ports:
//   cycle_cnt  : 32-bit count of active, non-halted cycles
//   instr_cnt  : 32-bit count of completed instructions, halt included
// -----------------------------------------------------------------------------
module multicycle_processor #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
`ifdef PROC_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_e              state_q, state_d;
    logic                active_q;            // 0 only in the first cycle after reset
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0]   alu_q, alu_d, md_q, md_d;
    logic                illegal_q, illegal_d;
    logic [DATA_W-1:0]   regs_q [16];
    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   rtype_res;
    logic [DATA_W-1:0]   br_off, jmp_off;

    logic [3:0] op;
    assign op = ir_q[15:12];

    // Branch offsets are halfword counts; the shift and the truncation to
    // ADDR_W give wrap-around PC arithmetic.
    assign br_off  = imm_q << 1;
    assign jmp_off = {{(DATA_W-12){ir_q[11]}}, ir_q[11:0]} << 1;

    always_comb begin
        rtype_res = '0;
        case (ir_q[3:0])
            4'd0:    rtype_res = a_q + b_q;
            4'd1:    rtype_res = a_q - b_q;
            4'd2:    rtype_res = a_q & b_q;
            4'd3:    rtype_res = a_q | b_q;
            4'd4:    rtype_res = a_q ^ b_q;
            4'd5:    rtype_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: rtype_res = '0;
        endcase
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        md_d      = md_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_wdata  = (op == OP_LW) ? md_q : alu_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;

        case (state_q)
            ST_FETCH: begin
                mem_req = active_q;
                if (active_q && mem_ack) begin
                    ir_d    = mem_rdata[15:0];
                    pc_d    = pc_q + ADDR_W'(2);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = regs_q[ir_q[7:4]];
                b_d     = regs_q[ir_q[11:8]];
                imm_d   = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_RTYPE: begin
                        alu_d   = rtype_res;
                        state_d = ST_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + imm_q;
                        state_d = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_q;
                        state_d = ST_MEM;
                    end
                    OP_BEQ:  if (a_q == b_q) pc_d = pc_q + br_off[ADDR_W-1:0];
                    OP_BNE:  if (a_q != b_q) pc_d = pc_q + br_off[ADDR_W-1:0];
                    OP_JMP:  pc_d = pc_q + jmp_off[ADDR_W-1:0];
                    OP_HALT: state_d = ST_HALT;
                    default: illegal_d = 1'b1;   // executes as a no-op
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (op == OP_SW);
                mem_addr = alu_q[ADDR_W-1:0];
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        state_d = ST_FETCH;
                    end else begin
                        md_d    = mem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            active_q  <= 1'b0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            md_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            md_q      <= md_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: the register file is reset to zero because software may read any
    // register before writing it; that rules out a reset-less RAM macro here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[ir_q[11:8]] <= rf_wdata;
        end
    end

    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

`ifdef PROC_PERF_CNT_EN
    logic        instr_done;
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // An instruction is complete on the edge that leaves its last state.
    always_comb begin
        instr_done = 1'b0;
        case (state_q)
            ST_EXEC: instr_done = !(op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW});
            ST_MEM:  instr_done = mem_ack && (op == OP_SW);
            ST_WB:   instr_done = 1'b1;
            default: instr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (active_q && state_q != ST_HALT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done)                     instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_processor.sv
// -----------------------------------------------------------------------------
// tb_multicycle_processor
//
// Directed bench for multicycle_processor (DATA_W = 32, ADDR_W = 16, RESET_PC
// = 0). A behavioural memory answers requests on the falling edge after a
// programmable number of wait cycles. It logs every store so results can be
// observed through the memory port. Unwritten memory holds halt instructions.
// -----------------------------------------------------------------------------
module tb_multicycle_processor;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr, pc;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              halted, illegal;
`ifdef PROC_PERF_CNT_EN
    logic [31:0]       cycle_cnt, instr_cnt;
`endif

    multicycle_processor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .halted(halted), .illegal(illegal)
`ifdef PROC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic [DATA_W-1:0] mem [0:127];
    wr_t               wr_q [$];
    int                ack_delay = 0;
    int                wait_cnt  = 0;
    int                pass_cnt  = 0;
    int                total_cnt = 0;

    // Memory model: ack after ack_delay wait cycles, one access per ack.
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            if (mem_we) begin
                mem[mem_addr[7:1]] = mem_wdata;
                wr_q.push_back('{mem_addr, mem_wdata});
            end else begin
                mem_rdata = mem[mem_addr[7:1]];
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    // Arithmetic program; every sw targets r0 + (-2) = 0xFFFE.
    localparam logic [15:0] PROG_ALU [18] = '{
        16'h1105, 16'h1203, 16'h0120, 16'h310E, 16'h0201, 16'h320E,
        16'h0425, 16'h340E, 16'h0124, 16'h1506, 16'h0512, 16'h0543,
        16'h350E, 16'h0126, 16'h310E, 16'h111F, 16'h310E, 16'hF000};
    localparam logic [31:0] ALU_EXP [6] = '{
        32'h0000_0008, 32'hFFFF_FFFD, 32'h0000_0001,
        32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_F000;
    endtask

    task automatic put(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] word);
        mem[addr[7:1]] = word;
    endtask

    // Leaves reset released on a falling edge; the next rising edge is E1.
    task automatic apply_reset(input int delay);
        reset     = 1'b1;
        ack_delay = delay;
        wr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) step(1);
    endtask

    task automatic test_reset();
        clear_mem();
        ack_delay = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", mem_req); else pass_cnt++;
        total_cnt++; if (pc !== 16'h0) $display("FAIL rst_pc: got %h exp 0000", pc); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b exp 0", halted); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b exp 0", illegal); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_pending_req: got %b exp 0", mem_req); else pass_cnt++;
        step(1);
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL rst_first_req: got %b exp 1", mem_req); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_first_we: got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_addr !== 16'h0) $display("FAIL rst_first_addr: got %h exp 0000", mem_addr); else pass_cnt++;
    endtask

    task automatic test_alu();
        clear_mem();
        for (int i = 0; i < 18; i++) put(ADDR_W'(2 * i), {16'h0, PROG_ALU[i]});
        apply_reset(0);
        step(1);
        step(12);   // three 4-cycle instructions
        total_cnt++; if (pc !== 16'h6) $display("FAIL alu_pc12: got %h exp 0006", pc); else pass_cnt++;
        total_cnt++; if (mem_addr !== 16'h6 || mem_req !== 1'b1)
            $display("FAIL alu_fetch12: got req=%b addr=%h exp req=1 addr=0006", mem_req, mem_addr); else pass_cnt++;
        run_until_halt(300);
        total_cnt++; if (halted !== 1'b1) $display("FAIL alu_halted: got %b exp 1", halted); else pass_cnt++;
        total_cnt++; if (pc !== 16'h24) $display("FAIL alu_final_pc: got %h exp 0024", pc); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL alu_illegal: got %b exp 0", illegal); else pass_cnt++;
        total_cnt++; if (wr_q.size() != 6) $display("FAIL alu_nstores: got %0d exp 6", wr_q.size()); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (i >= wr_q.size()) $display("FAIL alu_store%0d: got none exp %h", i, ALU_EXP[i]);
            else if (wr_q[i].data !== ALU_EXP[i] || wr_q[i].addr !== 16'hFFFE)
                $display("FAIL alu_store%0d: got %h@%h exp %h@fffe", i, wr_q[i].data, wr_q[i].addr, ALU_EXP[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_lw_wait();
        clear_mem();
        put(16'h00, 32'h0000_2304);   // lw r3,[r0+4]
        put(16'h02, 32'h0000_330E);   // sw r3,[r0-2]
        put(16'h04, 32'hDEAD_BEEF);   // data; fetched later as an undefined opcode
        put(16'h06, 32'h0000_F000);
        apply_reset(3);
        step(1);
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 16'h0)
            $display("FAIL lw_fetch: got req=%b addr=%h exp req=1 addr=0000", mem_req, mem_addr); else pass_cnt++;
        step(6);    // fetch 4 + decode + exec
        total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h4)
            $display("FAIL lw_mem: got req=%b we=%b addr=%h exp 1 0 0004", mem_req, mem_we, mem_addr); else pass_cnt++;
        step(2);
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 16'h4)
            $display("FAIL lw_mem_hold: got req=%b addr=%h exp 1 0004", mem_req, mem_addr); else pass_cnt++;
        step(2);
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL lw_wb_req: got %b exp 0", mem_req); else pass_cnt++;
        step(1);    // 11th cycle completes the load
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 16'h2)
            $display("FAIL lw_next_fetch: got req=%b addr=%h exp 1 0002", mem_req, mem_addr); else pass_cnt++;
        run_until_halt(300);
        total_cnt++; if (halted !== 1'b1) $display("FAIL lw_halted: got %b exp 1", halted); else pass_cnt++;
        total_cnt++; if (wr_q.size() != 1) $display("FAIL lw_nstores: got %0d exp 1", wr_q.size()); else pass_cnt++;
        total_cnt++;
        if (wr_q.size() == 0) $display("FAIL lw_store: got none exp deadbeef@fffe");
        else if (wr_q[0].data !== 32'hDEAD_BEEF || wr_q[0].addr !== 16'hFFFE)
            $display("FAIL lw_store: got %h@%h exp deadbeef@fffe", wr_q[0].data, wr_q[0].addr);
        else pass_cnt++;
        total_cnt++; if (illegal !== 1'b1) $display("FAIL lw_illegal: got %b exp 1", illegal); else pass_cnt++;
        total_cnt++; if (pc !== 16'h8) $display("FAIL lw_final_pc: got %h exp 0008", pc); else pass_cnt++;
    endtask

    task automatic test_branch();
        // Taken beq with a negative offset.
        clear_mem();
        put(16'h00, 32'h0000_6007);   // jmp +7 -> 0x10
        put(16'h10, 32'h0000_411E);   // beq r1,r1,-2 -> 0x0E
        apply_reset(0);
        step(1);
        step(3);
        total_cnt++; if (pc !== 16'h10 || mem_addr !== 16'h10)
            $display("FAIL jmp_target: got pc=%h addr=%h exp 0010", pc, mem_addr); else pass_cnt++;
        step(1);
        total_cnt++; if (pc !== 16'h12) $display("FAIL beq_pc_inc: got %h exp 0012", pc); else pass_cnt++;
        step(2);
        total_cnt++; if (pc !== 16'h0E || mem_addr !== 16'h0E || mem_req !== 1'b1)
            $display("FAIL beq_taken: got pc=%h addr=%h req=%b exp 000e 000e 1", pc, mem_addr, mem_req); else pass_cnt++;

        // Untaken bne, untaken beq, taken bne.
        clear_mem();
        put(16'h00, 32'h0000_6007);   // jmp +7 -> 0x10
        put(16'h10, 32'h0000_5114);   // bne r1,r1,+4: not taken
        put(16'h12, 32'h0000_1101);   // addi r1,r0,1
        put(16'h14, 32'h0000_4012);   // beq (r1,r0): not taken
        put(16'h16, 32'h0000_5013);   // bne (r1,r0),+3 -> 0x1E
        apply_reset(0);
        step(1);
        step(6);
        total_cnt++; if (pc !== 16'h12 || mem_addr !== 16'h12)
            $display("FAIL bne_not_taken: got pc=%h addr=%h exp 0012", pc, mem_addr); else pass_cnt++;
        run_until_halt(100);
        total_cnt++; if (halted !== 1'b1 || pc !== 16'h20)
            $display("FAIL branch_path: got halted=%b pc=%h exp 1 0020", halted, pc); else pass_cnt++;

        // PC wraps modulo 2^ADDR_W on a large backward jump.
        clear_mem();
        put(16'h00, 32'h0000_6800);   // jmp -2048 -> 0x0002 - 0x1000 = 0xF002
        apply_reset(0);
        step(1);
        step(3);
        total_cnt++; if (pc !== 16'hF002) $display("FAIL jmp_wrap: got %h exp f002", pc); else pass_cnt++;
    endtask

    task automatic test_illegal_halt();
        clear_mem();
        put(16'h00, 32'h0000_7000);   // undefined opcode
        put(16'h02, 32'h0000_F000);   // halt
        apply_reset(0);
        step(1);
        step(3);
        total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_flag: got %b exp 1", illegal); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 16'h2 || halted !== 1'b0)
            $display("FAIL ill_continue: got req=%b addr=%h halted=%b exp 1 0002 0", mem_req, mem_addr, halted); else pass_cnt++;
        step(3);
        total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag: got %b exp 1", halted); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            total_cnt++;
            if (mem_req !== 1'b0) $display("FAIL halt_req_c%0d: got %b exp 0", i, mem_req); else pass_cnt++;
            step(1);
        end
        total_cnt++; if (halted !== 1'b1 || illegal !== 1'b1 || pc !== 16'h4)
            $display("FAIL halt_hold: got halted=%b illegal=%b pc=%h exp 1 1 0004", halted, illegal, pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sw();
        clear_mem();
        put(16'h00, 32'h0000_310E);   // sw r1,[r0-2]
        apply_reset(3);
        step(1);
        step(7);    // fetch 4 + decode + exec, then one MEM wait cycle
        total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b1)
            $display("FAIL rsw_in_mem: got req=%b we=%b exp 1 1", mem_req, mem_we); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rsw_req: got %b exp 0", mem_req); else pass_cnt++;
        total_cnt++; if (pc !== 16'h0) $display("FAIL rsw_pc: got %h exp 0000", pc); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (wr_q.size() != 0) $display("FAIL rsw_no_write: got %0d stores exp 0", wr_q.size()); else pass_cnt++;
        step(1);
        total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0)
            $display("FAIL rsw_refetch: got req=%b we=%b addr=%h exp 1 0 0000", mem_req, mem_we, mem_addr); else pass_cnt++;
    endtask

`ifdef PROC_PERF_CNT_EN
    task automatic test_perf();
        clear_mem();
        put(16'h00, 32'h0000_1105);
        put(16'h02, 32'h0000_1203);
        put(16'h04, 32'h0000_1304);
        put(16'h06, 32'h0000_F000);
        apply_reset(0);
        step(1);
        run_until_halt(100);
        total_cnt++; if (instr_cnt !== 32'd4) $display("FAIL perf_instr: got %0d exp 4", instr_cnt); else pass_cnt++;
        total_cnt++; if (cycle_cnt !== 32'd15) $display("FAIL perf_cycle: got %0d exp 15", cycle_cnt); else pass_cnt++;
        step(5);
        total_cnt++; if (cycle_cnt !== 32'd15) $display("FAIL perf_cycle_halted: got %0d exp 15", cycle_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_mem();
        #2 reset = 1'b1;
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_illegal_halt();
        test_reset_mid_sw();
`ifdef PROC_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_processor.md
MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

Interface
REQ-001 Parameter DATA_W, default 16, register, ALU and memory data width (legal 16..64).
REQ-002 Parameter ADDR_W, default 16, PC and memory address width (legal 8..DATA_W).
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_req  output  1  memory access request, held until acknowledged.
REQ-007 mem_we  output  1  1 = write (sw), 0 = read (fetch or lw); valid while mem_req.
REQ-008 mem_addr  output  ADDR_W  byte address; valid while mem_req.
REQ-009 mem_wdata  output  DATA_W  store data; valid while mem_req and mem_we.
REQ-010 mem_rdata  input  DATA_W  read data, sampled on the edge where mem_ack=1.
REQ-011 mem_ack  input  1  access complete; ignored when mem_req=0.
REQ-012 pc  output  ADDR_W  current PC (debug).
REQ-013 halted  output  1  core stopped after halt instruction.
REQ-014 illegal  output  1  sticky: undefined opcode was decoded.

Function
REQ-015 Instruction fields: op=[15:12], dest=[11:8], src=[7:4], imm/fn=[3:0], joff=[11:0]; fetch uses mem_rdata[15:0].
REQ-016 Opcodes: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 bne, 0110 jmp, 1111 halt; all others illegal.
REQ-017 R-type fn: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed, result 0/1); other fn values write 0.
REQ-018 Operands: A=R[src], B=R[dest]; R-type/addi/lw write R[dest]; sw stores R[dest] at A+sext(imm).
REQ-019 Register file: 16 x DATA_W, all writable, no hardwired zero; arithmetic wraps modulo 2^DATA_W.
REQ-020 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack latch IR, pc<=pc+2, go DECODE.
REQ-022 DECODE: latch A, B, sext(imm) to DATA_W; go EXEC.
REQ-023 EXEC: R-type/addi/lw/sw latch ALU result, go WB (R/addi) or MEM (lw/sw).
REQ-024 EXEC beq (A==B) / bne (A!=B): if taken pc<=pc+(sext(imm)<<1), else pc unchanged; go FETCH.
REQ-025 EXEC jmp: pc<=pc+(sext(joff)<<1), go FETCH; halt: go HALT; illegal: set illegal, go FETCH (no-op).
REQ-026 MEM: mem_req=1, mem_addr=ALU result[ADDR_W-1:0]; on ack, lw latches mem_rdata, go WB; sw go FETCH.
REQ-027 WB: write R[dest] in this state's edge, go FETCH.
REQ-028 Zero-wait latencies: R/addi 4 cycles, lw 5, sw 4, beq/bne/jmp 3.
REQ-029 mem_req deasserts the cycle after the acknowledging edge; each wait cycle with mem_ack=0 adds one cycle, outputs held stable.
REQ-030 PC arithmetic wraps modulo 2^ADDR_W.
REQ-031 HALT is terminal: mem_req=0, halted=1, until reset.

Reset
REQ-032 On reset asserted, immediately: state=FETCH-pending, pc=RESET_PC, mem_req=0, halted=0, illegal=0, all registers 0.
REQ-033 Reset mid-access abandons the transaction; first request after release is a fetch at RESET_PC, issued the first edge after reset deasserts.

Configuration
REQ-034 Macro PROC_PERF_CNT_EN defined: add outputs cycle_cnt (32, counts every non-reset, non-HALT cycle) and instr_cnt (32, increments per instruction completed, halt included); both wrap, reset to 0.
REQ-035 PROC_PERF_CNT_EN undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-036 Zero-wait memory, addi r1,r0,5; addi r2,r0,3; R-add r1,r2 -> r1=8 after 12 cycles, pc=RESET_PC+6.
REQ-037 DATA_W=32, ack delayed 3 cycles per access, lw r3,[r0+4] with mem word 0xDEADBEEF -> r3=0xDEADBEEF, instruction takes 11 cycles.
REQ-038 beq r1,r1,-2 at pc 0x10 -> next fetch at 0x0E; bne r1,r1,+4 -> next fetch at 0x12.
REQ-039 Opcode 0111 then halt -> illegal=1, halted=1, mem_req stays 0 for 20 cycles.
REQ-040 Assert reset during MEM wait of a sw -> no write issued, mem_req=0, pc=RESET_PC; next fetch after release at RESET_PC.
REQ-041 With PROC_PERF_CNT_EN, run 3 addi + halt zero-wait -> instr_cnt=4, cycle_cnt=15.
